// File: rtl/mp_evb_queue.sv
// mp_evb_queue: management-bus (EVB) access unit for the execute stage.
// Writes are posted into a DEPTH-entry in-order queue. Reads stall the pipeline
// until they write back. A per-transaction watchdog turns a hung bus access into
// an err pulse and, for reads, a forced all-ones writeback.
//
// Ports
//   sysclk, sys_setn       clock, synchronous active-low reset
//   issue/rwn/tag2/sel     access request from issue (tag2: 0=W, 1=H, 2=L)
//   addr_in/data_in        register address and write data
//   stall                  pipeline hold (queue full or read outstanding)
//   wb/wb32/wb_data        read writeback pulse, width flag, result
//   err/err_addr           timeout abort pulse and the aborted address
//   mgmt_*                 management bus request/response
module mp_evb_queue #(
  parameter int unsigned AW      = 13,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          sysclk,
  input  logic          sys_setn,
  input  logic          issue,
  input  logic          rwn,
  input  logic [1:0]    tag2,
  input  logic          sel,
  input  logic [AW-1:0] addr_in,
  input  logic [31:0]   data_in,
  output logic          stall,
  output logic          wb,
  output logic          wb32,
  output logic [31:0]   wb_data,
  output logic          err,
  output logic [31:0]   err_addr,
  output logic          mgmt_req,
  output logic [31:0]   mgmt_adr,
  input  logic          mgmt_ack,
  output logic          mgmt_rwn,
  output logic [1:0]    mgmt_wen,
  output logic [31:0]   mgmt_txd,
  input  logic          mgmt_rxe,
  input  logic [31:0]   mgmt_rxd
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] TAG_H = 2'd1;
  localparam logic [1:0] TAG_L = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  // Queue storage
  logic          r_q_rwn  [DEPTH];
  logic [1:0]    r_q_wen  [DEPTH];
  logic [1:0]    r_q_tag  [DEPTH];
  logic [AW-1:0] r_q_addr [DEPTH];
  logic [31:0]   r_q_txd  [DEPTH];

  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_rd_pend;
  logic          r_stall;

  state_t        r_state;
  logic [TW-1:0] r_tmo;
  logic          r_wb;
  logic          r_wb32;
  logic [31:0]   r_wb_data;
  logic          r_err;
  logic [31:0]   r_err_addr;
  logic          r_mgmt_req;
  logic [31:0]   r_mgmt_adr;
  logic          r_mgmt_rwn;
  logic [1:0]    r_mgmt_wen;
  logic [31:0]   r_mgmt_txd;

  logic [15:0]   w_half;
  logic [1:0]    w_wen;
  logic [31:0]   w_txd;
  logic          w_enq;
  logic          w_h_rwn;
  logic [1:0]    w_h_tag;
  logic [AW-1:0] w_h_addr;
  logic          w_h_is32;
  logic [31:0]   w_h_rdfmt;
  logic          w_busy;
  logic          w_abort;
  logic          w_done;
  logic          w_pop;
  logic [CW-1:0] w_count_nxt;
  logic          w_rd_pend_nxt;

  assign stall    = r_stall;
  assign wb       = r_wb;
  assign wb32     = r_wb32;
  assign wb_data  = r_wb_data;
  assign err      = r_err;
  assign err_addr = r_err_addr;
  assign mgmt_req = r_mgmt_req;
  assign mgmt_adr = r_mgmt_adr;
  assign mgmt_rwn = r_mgmt_rwn;
  assign mgmt_wen = r_mgmt_wen;
  assign mgmt_txd = r_mgmt_txd;

  // Lane enables and write-data placement for a new entry
  always_comb begin
    w_half = sel ? data_in[31:16] : data_in[15:0];
    w_wen  = 2'b11;
    w_txd  = data_in;
    case (tag2)
      TAG_H: begin
        w_wen = 2'b10;
        w_txd = {w_half, 16'h0000};
      end
      TAG_L: begin
        w_wen = 2'b01;
        w_txd = {16'h0000, w_half};
      end
      default: ;
    endcase
  end

  assign w_enq    = issue & ~r_stall;
  assign w_h_rwn  = r_q_rwn[r_rptr];
  assign w_h_tag  = r_q_tag[r_rptr];
  assign w_h_addr = r_q_addr[r_rptr];
  assign w_h_is32 = (w_h_tag != TAG_H) && (w_h_tag != TAG_L);

  // Read result formatting: H replicates the upper halfword
  assign w_h_rdfmt = (w_h_tag == TAG_H) ? {mgmt_rxd[31:16], mgmt_rxd[31:16]} : mgmt_rxd;

  // Abort wins over any ack/rxe arriving in the same cycle
  assign w_busy  = (r_state == ST_REQ) || (r_state == ST_WAIT);
  assign w_abort = w_busy && (r_tmo == TW'(TIMEOUT - 1));
  assign w_done  = !w_abort &&
                   (((r_state == ST_REQ) && mgmt_ack && (!w_h_rwn || mgmt_rxe)) ||
                    ((r_state == ST_WAIT) && mgmt_rxe));
  assign w_pop   = w_abort | w_done;

  assign w_count_nxt   = r_count + CW'(w_enq) - CW'(w_pop);
  assign w_rd_pend_nxt = (w_enq && rwn) ? 1'b1 :
                         (w_pop && w_h_rwn) ? 1'b0 : r_rd_pend;

  // Queue storage write port
  always_ff @(posedge sysclk) begin
    if (w_enq) begin
      r_q_rwn[r_wptr]  <= rwn;
      r_q_wen[r_wptr]  <= w_wen;
      r_q_tag[r_wptr]  <= tag2;
      r_q_addr[r_wptr] <= addr_in;
      r_q_txd[r_wptr]  <= w_txd;
    end
  end

  // Queue pointers, occupancy and pipeline stall
  always_ff @(posedge sysclk) begin
    if (!sys_setn) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_rd_pend <= 1'b0;
      r_stall   <= 1'b0;
    end else begin
      if (w_enq) r_wptr <= r_wptr + PW'(1);
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      r_count   <= w_count_nxt;
      r_rd_pend <= w_rd_pend_nxt;
      r_stall   <= (w_count_nxt == CW'(DEPTH)) | w_rd_pend_nxt;
    end
  end

  // Bus FSM with watchdog, writeback and error reporting
  always_ff @(posedge sysclk) begin
    if (!sys_setn) begin
      r_state    <= ST_IDLE;
      r_tmo      <= '0;
      r_wb       <= 1'b0;
      r_wb32     <= 1'b0;
      r_wb_data  <= '0;
      r_err      <= 1'b0;
      r_err_addr <= '0;
      r_mgmt_req <= 1'b0;
      r_mgmt_adr <= '0;
      r_mgmt_rwn <= 1'b0;
      r_mgmt_wen <= '0;
      r_mgmt_txd <= '0;
    end else begin
      r_wb  <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_count != '0) begin
            r_state    <= ST_REQ;
            r_tmo      <= '0;
            r_mgmt_req <= 1'b1;
            r_mgmt_adr <= 32'(w_h_addr);
            r_mgmt_rwn <= w_h_rwn;
            r_mgmt_wen <= r_q_wen[r_rptr];
            r_mgmt_txd <= r_q_txd[r_rptr];
          end
        end
        ST_REQ, ST_WAIT: begin
          r_tmo <= r_tmo + TW'(1);
          if (w_abort || w_done || mgmt_ack) begin
            // Bus fields return to zero whenever the request phase ends
            r_mgmt_req <= 1'b0;
            r_mgmt_adr <= '0;
            r_mgmt_rwn <= 1'b0;
            r_mgmt_wen <= '0;
            r_mgmt_txd <= '0;
          end
          if (w_abort) begin
            r_state    <= ST_IDLE;
            r_err      <= 1'b1;
            r_err_addr <= 32'(w_h_addr);
            if (w_h_rwn) begin
              r_wb      <= 1'b1;
              r_wb_data <= 32'hFFFF_FFFF;
              r_wb32    <= w_h_is32;
            end
          end else if (w_done) begin
            r_state <= ST_IDLE;
            if (w_h_rwn) begin
              r_wb      <= 1'b1;
              r_wb_data <= w_h_rdfmt;
              r_wb32    <= w_h_is32;
            end
          end else if ((r_state == ST_REQ) && mgmt_ack) begin
            r_state <= ST_WAIT;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mp_evb_queue.sv
// Self-checking bench for mp_evb_queue: directed scenarios plus randomized
// traffic, checked every cycle against a transaction-level reference model.
module tb_mp_evb_queue;

  localparam int unsigned AW      = 13;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 8;

  logic          sysclk = 1'b0;
  logic          sys_setn;
  logic          issue;
  logic          rwn;
  logic [1:0]    tag2;
  logic          sel;
  logic [AW-1:0] addr_in;
  logic [31:0]   data_in;
  logic          stall;
  logic          wb;
  logic          wb32;
  logic [31:0]   wb_data;
  logic          err;
  logic [31:0]   err_addr;
  logic          mgmt_req;
  logic [31:0]   mgmt_adr;
  logic          mgmt_ack;
  logic          mgmt_rwn;
  logic [1:0]    mgmt_wen;
  logic [31:0]   mgmt_txd;
  logic          mgmt_rxe;
  logic [31:0]   mgmt_rxd;

  always #5 sysclk = ~sysclk;

  mp_evb_queue #(.AW(AW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) u_dut (
    .sysclk   (sysclk),
    .sys_setn (sys_setn),
    .issue    (issue),
    .rwn      (rwn),
    .tag2     (tag2),
    .sel      (sel),
    .addr_in  (addr_in),
    .data_in  (data_in),
    .stall    (stall),
    .wb       (wb),
    .wb32     (wb32),
    .wb_data  (wb_data),
    .err      (err),
    .err_addr (err_addr),
    .mgmt_req (mgmt_req),
    .mgmt_adr (mgmt_adr),
    .mgmt_ack (mgmt_ack),
    .mgmt_rwn (mgmt_rwn),
    .mgmt_wen (mgmt_wen),
    .mgmt_txd (mgmt_txd),
    .mgmt_rxe (mgmt_rxe),
    .mgmt_rxd (mgmt_rxd)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        rwn;
    logic [1:0]  tag;
    logic [1:0]  wen;
    logic [31:0] addr;
    logic [31:0] txd;
  } txn_t;

  txn_t        m_q[$];
  int          m_phase = 0;      // 0 idle, 1 request on bus, 2 awaiting read data
  int          m_age = 0;        // cycles spent by the head access on the bus
  bit          m_rd_pend = 0;
  logic [31:0] m_err_addr = '0;
  bit          e_wb, e_wb32, e_err;
  logic [31:0] e_wb_data;

  function automatic logic [1:0] ref_wen(input logic [1:0] t);
    return (t == 2'd1) ? 2'b10 : (t == 2'd2) ? 2'b01 : 2'b11;
  endfunction

  function automatic logic [31:0] ref_txd(input logic [1:0] t, input logic s, input logic [31:0] d);
    logic [15:0] h;
    h = s ? d[31:16] : d[15:0];
    if (t == 2'd1) return {h, 16'h0};
    if (t == 2'd2) return {16'h0, h};
    return d;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [1:0] t, input logic [31:0] d);
    return (t == 2'd1) ? {d[31:16], d[31:16]} : d;
  endfunction

  // ---------------- bus responder state ----------------
  bit          rsp_rand = 0;
  int          ack_lat = 0;      // request cycles before ack; -1 = never
  int          rxe_lat = 0;      // cycles after ack before rxe; 0 = with ack, -1 = never
  logic [31:0] rsp_rxd = '0;
  bit          force_rxe = 0;
  int          req_age = 0;
  bit          waiting = 0;
  int          wait_age = 0;

  // ---------------- observation helpers ----------------
  logic [33:0] bus_log[$];
  bit          wb_seen, err_seen, stall_seen;
  logic [31:0] last_wb_data;
  bit          last_wb32;
  int          req_cnt;

  task automatic bus_resp();
    if (rsp_rand) begin
      mgmt_rxd = $urandom;
      mgmt_ack = mgmt_req ? ($urandom_range(0, 99) < 45) : ($urandom_range(0, 99) < 10);
      mgmt_rxe = ($urandom_range(0, 99) < 35);
    end else begin
      mgmt_rxd = rsp_rxd;
      mgmt_ack = mgmt_req && (ack_lat >= 0) && (req_age >= ack_lat);
      mgmt_rxe = force_rxe;
      if (mgmt_ack && mgmt_rwn && rxe_lat == 0) mgmt_rxe = 1'b1;
      if (!mgmt_req && waiting && rxe_lat > 0 && wait_age >= rxe_lat - 1) mgmt_rxe = 1'b1;
    end
  endtask

  task automatic tick();
    bit          s_rst, s_iss, s_rwn, s_sel, s_ack, s_rxe, s_req, s_brwn, m_stall, pop;
    logic [1:0]  s_tag;
    logic [31:0] s_addr, s_data, s_rxd, exp_adr, exp_txd;
    logic        exp_rwn;
    logic [1:0]  exp_wen;
    txn_t        t, n;
    bus_resp();
    s_rst = !sys_setn; s_iss = issue; s_rwn = rwn; s_sel = sel; s_tag = tag2;
    s_addr = 32'(addr_in); s_data = data_in;
    s_ack = mgmt_ack; s_rxe = mgmt_rxe; s_rxd = mgmt_rxd; s_req = mgmt_req; s_brwn = mgmt_rwn;
    m_stall = (m_q.size() == DEPTH) || m_rd_pend;
    if (mgmt_req && mgmt_ack) bus_log.push_back({mgmt_wen, mgmt_txd});
    @(posedge sysclk);
    #1;
    e_wb = 0; e_err = 0; pop = 0;
    if (s_rst) begin
      m_q.delete(); m_phase = 0; m_age = 0; m_rd_pend = 0; m_err_addr = '0;
      req_age = 0; waiting = 0; wait_age = 0;
    end else begin
      if (m_phase == 0) begin
        if (m_q.size() > 0) begin m_phase = 1; m_age = 0; end
      end else begin
        m_age++;
        t = m_q[0];
        if (m_age == TIMEOUT) begin
          pop = 1; e_err = 1; m_err_addr = t.addr;
          if (t.rwn) begin e_wb = 1; e_wb_data = 32'hFFFF_FFFF; e_wb32 = (t.tag != 2'd1 && t.tag != 2'd2); end
        end else if (m_phase == 1 && s_ack && !t.rwn) begin
          pop = 1;
        end else if ((m_phase == 1 && s_ack && s_rxe) || (m_phase == 2 && s_rxe)) begin
          pop = 1; e_wb = 1; e_wb_data = ref_rd(t.tag, s_rxd);
          e_wb32 = (t.tag != 2'd1 && t.tag != 2'd2);
        end else if (m_phase == 1 && s_ack) begin
          m_phase = 2;
        end
        if (pop) begin
          void'(m_q.pop_front());
          m_phase = 0;
          if (t.rwn) m_rd_pend = 0;
        end
      end
      if (s_iss && !m_stall) begin
        n.rwn = s_rwn; n.tag = s_tag; n.wen = ref_wen(s_tag);
        n.addr = s_addr; n.txd = ref_txd(s_tag, s_sel, s_data);
        m_q.push_back(n);
        if (s_rwn) m_rd_pend = 1;
      end
      // responder bookkeeping
      if (s_req && !s_ack) req_age++; else req_age = 0;
      if (s_req && s_ack && s_brwn && !s_rxe) begin waiting = 1; wait_age = 0; end
      else if (waiting) begin if (s_rxe || s_req) waiting = 0; else wait_age++; end
    end
    // compare DUT against model
    chk("stall", stall, (m_q.size() == DEPTH) || m_rd_pend);
    chk("mgmt_req", mgmt_req, m_phase == 1);
    exp_rwn = 0; exp_wen = 0; exp_adr = 0; exp_txd = 0;
    if (m_phase == 1) begin
      exp_rwn = m_q[0].rwn; exp_wen = m_q[0].wen; exp_adr = m_q[0].addr; exp_txd = m_q[0].txd;
    end
    chk("bus_ctl", {mgmt_rwn, mgmt_wen, mgmt_adr}, {exp_rwn, exp_wen, exp_adr});
    chk("bus_txd", mgmt_txd, exp_txd);
    if (e_wb) chk("wb", {wb, wb32, wb_data}, {1'b1, e_wb32, e_wb_data});
    else      chk("wb", wb, 1'b0);
    chk("err", {err, err_addr}, {e_err, m_err_addr});
    if (wb) begin wb_seen = 1; last_wb_data = wb_data; last_wb32 = wb32; end
    if (err) err_seen = 1;
    if (stall) stall_seen = 1;
    if (mgmt_req) req_cnt++;
  endtask

  task automatic do_issue(input bit r, input logic [1:0] t, input bit s,
                          input logic [AW-1:0] a, input logic [31:0] d);
    issue = 1; rwn = r; tag2 = t; sel = s; addr_in = a; data_in = d;
    tick();
    issue = 0;
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while ((m_q.size() != 0 || m_phase != 0 || mgmt_req) && n < max_cyc) begin tick(); n++; end
    chk("drain_bound", m_q.size(), 0);
  endtask

  task automatic clear_obs();
    bus_log.delete(); wb_seen = 0; err_seen = 0; stall_seen = 0; req_cnt = 0;
  endtask

  initial begin
    int n;
    sys_setn = 0; issue = 0; rwn = 0; tag2 = 0; sel = 0; addr_in = '0; data_in = '0;
    mgmt_ack = 0; mgmt_rxe = 0; mgmt_rxd = '0;
    repeat (2) tick();
    chk("rst_wb_data", wb_data, 32'h0);
    sys_setn = 1;
    tick();

    // Posted writes, ack one cycle into each request
    clear_obs(); ack_lat = 1; rxe_lat = 0;
    do_issue(0, 2'd0, 0, 13'h0010, 32'h1234_5678);
    do_issue(0, 2'd1, 1, 13'h0011, 32'hABCD_0000);
    do_issue(0, 2'd2, 0, 13'h0012, 32'h0000_5555);
    drain(60);
    chk("t1_stall", stall_seen, 0);
    chk("t1_count", bus_log.size(), 3);
    if (bus_log.size() == 3) begin
      chk("t1_tx0", bus_log[0], {2'b11, 32'h1234_5678});
      chk("t1_tx1", bus_log[1], {2'b10, 32'hABCD_0000});
      chk("t1_tx2", bus_log[2], {2'b01, 32'h0000_5555});
    end

    // Halfword read, data two cycles after ack
    clear_obs(); ack_lat = 0; rxe_lat = 2; rsp_rxd = 32'hBEEF_1234;
    do_issue(1, 2'd1, 0, 13'h0020, 32'h0);
    chk("t2_stall_on", stall, 1);
    n = 0;
    while (!wb && n < 30) begin tick(); n++; end
    chk("t2_wb", wb, 1);
    chk("t2_data", wb_data, 32'hBEEF_BEEF);
    chk("t2_wb32", wb32, 0);
    chk("t2_stall_off", stall, 0);
    drain(20);

    // Fill the queue with ack held low; the fifth issue must be dropped
    clear_obs(); ack_lat = -1;
    for (int i = 0; i < 5; i++) begin
      do_issue(0, 2'd0, 0, AW'(13'h0100 + i), 32'h1000_0000 + i);
      if (i == 3) chk("t3_full", stall, 1);
    end
    ack_lat = 0;
    drain(80);
    chk("t3_drained", bus_log.size(), 4);
    chk("t3_noerr", err_seen, 0);

    // Read with ack and rxe together: no wait cycle
    clear_obs(); ack_lat = 0; rxe_lat = 0; rsp_rxd = 32'hCAFE_F00D;
    do_issue(1, 2'd0, 0, 13'h0030, 32'h0);
    n = 1;
    while (!wb && n < 20) begin tick(); n++; end
    chk("t4_lat", n, 3);
    chk("t4_data", wb_data, 32'hCAFE_F00D);
    chk("t4_wb32", wb32, 1);
    drain(20);

    // Hung read: watchdog aborts
    clear_obs(); ack_lat = -1;
    do_issue(1, 2'd0, 0, 13'h1ABC, 32'h0);
    n = 0;
    while (!err && n < 40) begin tick(); n++; end
    chk("t5_err", err, 1);
    chk("t5_req_cycles", req_cnt, TIMEOUT);
    chk("t5_err_addr", err_addr, 32'h0000_1ABC);
    chk("t5_wb", {wb, wb_data}, {1'b1, 32'hFFFF_FFFF});
    chk("t5_stall", stall, 0);
    drain(20);

    // Reset while a read waits for data; late rxe must be ignored
    clear_obs(); ack_lat = 0; rxe_lat = -1;
    do_issue(0, 2'd0, 0, 13'h0040, 32'h1);
    do_issue(0, 2'd0, 0, 13'h0041, 32'h2);
    do_issue(1, 2'd0, 0, 13'h0042, 32'h0);
    n = 0;
    while (m_phase != 2 && n < 30) begin tick(); n++; end
    chk("t6_in_wait", m_phase, 2);
    sys_setn = 0;
    tick();
    sys_setn = 1;
    chk("t6_req", mgmt_req, 0);
    chk("t6_stall", stall, 0);
    wb_seen = 0; force_rxe = 1;
    repeat (3) tick();
    force_rxe = 0;
    chk("t6_no_wb", wb_seen, 0);

    // Randomized traffic
    rsp_rand = 1;
    for (int c = 0; c < 1500; c++) begin
      issue   = ($urandom_range(0, 99) < 50);
      rwn     = ($urandom_range(0, 99) < 20);
      tag2    = 2'($urandom_range(0, 2));
      sel     = 1'($urandom);
      addr_in = AW'($urandom);
      data_in = $urandom;
      sys_setn = ($urandom_range(0, 399) != 0);
      tick();
    end
    issue = 0; sys_setn = 1;
    drain(200);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
